sample_deser: RTL

//  Receive end of the DDS serial sample link: deserializes one MSB-first serial word per frame.

---
 rtl/sample_deser.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/sample_deser.sv
// sample_deser: receive end of the DDS serial sample link.
// Deserializes one MSB-first word per frame. A frame is a syncI pulse on the MSB
// cycle, DATA_W data bits (one per clock), then GAP_CYC overhead cycles. Words are
// handed to the consumer through a single holding register with valid/ready.
//
// Optional feature macro: SAMPLE_DESER_PARITY_EN
//   When defined, an even-parity bit follows the LSB. It occupies the first gap slot.
//   The word loads one cycle later, and only if the parity check passes.
//
// Ports:
//   clkI       in   1       system clock, posedge
//   rstnI      in   1       async active-low reset
//   serI       in   1       serial data bit
//   syncI      in   1       frame start, high on the MSB cycle only
//   dataO      out  DATA_W  received word, stable while validO=1
//   validO     out  1       word available
//   readyI     in   1       consumer accepts (transfer on validO & readyI)
//   busyO      out  1       receiving a frame (SHIFT or PARITY)
//   ovfO       out  1       pulse: unaccepted word overwritten
//   frameErrO  out  1       pulse: sync arrived mid-frame or in the gap
//   parErrO    out  1       pulse: parity mismatch (always 0 without the feature)
module sample_deser #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clkI,
  input  logic              rstnI,
  input  logic              serI,
  input  logic              syncI,
  output logic [DATA_W-1:0] dataO,
  output logic              validO,
  input  logic              readyI,
  output logic              busyO,
  output logic              ovfO,
  output logic              frameErrO,
  output logic              parErrO
);

  localparam int unsigned CntW = $clog2(DATA_W + GAP_CYC + 1);
`ifdef SAMPLE_DESER_PARITY_EN
  // The parity slot consumes the first gap cycle.
  localparam int unsigned GapLen = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  // The full word is held until the parity bit has been checked.
  localparam int unsigned ShW    = DATA_W;
`else
  localparam int unsigned GapLen = GAP_CYC;
  // The LSB goes straight from serI into the output word.
  localparam int unsigned ShW    = DATA_W - 1;
`endif
  localparam int unsigned    GapLast = (GapLen > 0) ? GapLen - 1 : 0;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] GapEnd  = CntW'(GapLast);

  typedef enum logic [1:0] {StIdle, StShift, StParity, StGap} state_e;

  state_e            r_state, w_state_nxt;
  logic [CntW-1:0]   r_bitcnt, w_bitcnt_nxt;
  logic [CntW-1:0]   r_gapcnt, w_gapcnt_nxt;
  logic [ShW-1:0]    r_shreg, w_shreg_nxt;
  logic [ShW:0]      w_shift;
  logic [DATA_W-1:0] w_word;
  logic              w_load, w_ferr, w_perr;

  logic [DATA_W-1:0] r_data;
  logic              r_valid, r_ovf, r_ferr, r_perr;

  assign w_shift = {r_shreg, serI};

  // State and counter registers
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      r_state  <= StIdle;
      r_bitcnt <= '0;
      r_gapcnt <= '0;
      r_shreg  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_gapcnt <= w_gapcnt_nxt;
      r_shreg  <= w_shreg_nxt;
    end
  end

  // Next-state, counters and word-load decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_gapcnt_nxt = r_gapcnt;
    w_shreg_nxt  = r_shreg;
    w_word       = '0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    w_perr       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (syncI) begin
          w_shreg_nxt  = ShW'(serI);
          w_bitcnt_nxt = CntW'(1);
          w_state_nxt  = StShift;
        end
      end
      StShift: begin
        if (syncI) begin
          // Restart: the partial word is dropped and this bit is the new MSB.
          w_ferr       = 1'b1;
          w_shreg_nxt  = ShW'(serI);
          w_bitcnt_nxt = CntW'(1);
        end else begin
          w_shreg_nxt  = w_shift[ShW-1:0];
          w_bitcnt_nxt = r_bitcnt + 1'b1;
          if (r_bitcnt == LastBit) begin
            w_bitcnt_nxt = '0;
            w_gapcnt_nxt = '0;
`ifdef SAMPLE_DESER_PARITY_EN
            w_state_nxt  = StParity;
`else
            w_load       = 1'b1;
            w_word       = w_shift;
            w_state_nxt  = (GapLen > 0) ? StGap : StIdle;
`endif
          end
        end
      end
      StParity: begin
`ifdef SAMPLE_DESER_PARITY_EN
        if (syncI) begin
          w_ferr       = 1'b1;
          w_shreg_nxt  = ShW'(serI);
          w_bitcnt_nxt = CntW'(1);
          w_state_nxt  = StShift;
        end else begin
          // Even parity: data bits XOR parity bit must be zero.
          if (^w_shift == 1'b0) begin
            w_load = 1'b1;
            w_word = r_shreg;
          end else begin
            w_perr = 1'b1;
          end
          w_gapcnt_nxt = '0;
          w_state_nxt  = (GapLen > 0) ? StGap : StIdle;
        end
`else
        w_state_nxt = StIdle;
`endif
      end
      StGap: begin
        if (syncI) begin
          // Early sync is flagged but still honoured as a frame start.
          w_ferr       = 1'b1;
          w_shreg_nxt  = ShW'(serI);
          w_bitcnt_nxt = CntW'(1);
          w_gapcnt_nxt = '0;
          w_state_nxt  = StShift;
        end else if (r_gapcnt == GapEnd) begin
          w_gapcnt_nxt = '0;
          w_state_nxt  = StIdle;
        end else begin
          w_gapcnt_nxt = r_gapcnt + 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Holding register, handshake and error pulses
  always_ff @(posedge clkI or negedge rstnI) begin
    if (!rstnI) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      if (w_load) begin
        r_data <= w_word;
      end
      // A load on the same edge as an accept keeps valid high.
      r_valid <= w_load | (r_valid & ~readyI);
      r_ovf   <= w_load & r_valid & ~readyI;
      r_ferr  <= w_ferr;
      r_perr  <= w_perr;
    end
  end

  // Outputs
  always_comb begin
    busyO     = (r_state == StShift) || (r_state == StParity);
    dataO     = r_data;
    validO    = r_valid;
    ovfO      = r_ovf;
    frameErrO = r_ferr;
`ifdef SAMPLE_DESER_PARITY_EN
    parErrO   = r_perr;
`else
    parErrO   = 1'b0;
`endif
  end

endmodule
